// File: rtl/clock_pkg.sv
// Shared chime constants, state encoding and expected-time helper.
// STRIKE state exists only when CHIME_STRIKE_EN is defined.
package clock_pkg;

  localparam int          DEF_DIV_LO = 4;
  localparam int          DEF_DIV_HI = 2;
  localparam logic [15:0] T_START    = 16'h5950;
  localparam logic [15:0] T_END      = 16'h5959;

`ifdef CHIME_STRIKE_EN
  typedef enum logic [2:0] {IDLE, ARM, LO, GAP, HI, STRIKE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, LO, GAP, HI} state_t;
`endif

  // idx counts seconds since 59:50; idx >= 10 maps onto 00:(idx-10).
  function automatic logic [15:0] exp_time(input logic [5:0] idx);
    logic [5:0] v, tens, units;
    if (idx < 6'd10) return T_START + {10'd0, idx};
    v     = idx - 6'd10;
    tens  = (v >= 6'd50) ? 6'd5 : (v >= 6'd40) ? 6'd4 : (v >= 6'd30) ? 6'd3 :
            (v >= 6'd20) ? 6'd2 : (v >= 6'd10) ? 6'd1 : 6'd0;
    units = v - tens * 6'd10;
    return {8'h00, 4'(tens), 4'(units)};
  endfunction

  function automatic logic is_tone(input state_t s);
`ifdef CHIME_STRIKE_EN
    return (s == LO) || (s == HI) || (s == STRIKE);
`else
    return (s == LO) || (s == HI);
`endif
  endfunction

endpackage

// File: rtl/chime_gen_tone_div.sv
// Square-wave tone divider: Beep toggles each time the 8-bit count hits DIV-1.
module tone_div import clock_pkg::*; #(
  parameter int DIV_LO = DEF_DIV_LO,
  parameter int DIV_HI = DEF_DIV_HI
) (
  input  logic CP,
  input  logic nCR,
  input  logic clr,
  input  logic sel_hi,
  output logic Beep
);

  logic [7:0] cnt;
  logic [7:0] lim;

  assign lim = sel_hi ? 8'(DIV_HI - 1) : 8'(DIV_LO - 1);

  // clr is held for the whole of every silent state and pulsed on tone entry.
  always_ff @(posedge CP) begin
    if (!nCR || clr) begin
      cnt  <= 8'd0;
      Beep <= 1'b0;
    end else if (cnt == lim) begin
      cnt  <= 8'd0;
      Beep <= ~Beep;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/chime_gen.sv
// Top-of-hour chime sequencer: four low pips, one high pip, optional hour strike.
// Hour striking (HrH/HrL ports, STRIKE state) is compiled in by CHIME_STRIKE_EN.
module chime_gen import clock_pkg::*; #(
  parameter int DIV_LO = DEF_DIV_LO,
  parameter int DIV_HI = DEF_DIV_HI
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       Tick,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
`ifdef CHIME_STRIKE_EN
  input  logic [3:0] HrH,
  input  logic [3:0] HrL,
`endif
  input  logic       ChimeOn,
  output logic       Beep,
  output logic       EN,
  output logic       Busy
);

  state_t      state, nxt;
  logic [5:0]  idx, idx_nxt, n;
  logic [15:0] now, want;
  logic        clr, sel_hi;

`ifdef CHIME_STRIKE_EN
  logic [3:0] nstrk, nstrk_nxt, hr12;
  logic [4:0] hr;
  logic [5:0] s;

  assign hr   = 5'(HrH) * 5'd10 + 5'(HrL);
  assign hr12 = (hr == 5'd0 || hr == 5'd12) ? 4'd12 :
                (hr > 5'd12) ? 4'(hr - 5'd12) : hr[3:0];
  assign s    = n - 6'd10;
`endif

  assign now  = {MinH, MinL, SecH, SecL};
  assign n    = idx + 6'd1;
  assign want = exp_time(n);

  always_comb begin
    nxt     = state;
    idx_nxt = idx;
`ifdef CHIME_STRIKE_EN
    nstrk_nxt = nstrk;
`endif
    if (Tick) begin
      if (state == IDLE) begin
        if (ChimeOn && now == T_START) begin
          nxt     = ARM;
          idx_nxt = 6'd0;
        end
      end else if (now != want || !ChimeOn) begin
        // time was set/adjusted, or the user disabled the chime
        nxt     = IDLE;
        idx_nxt = 6'd0;
      end else begin
        idx_nxt = n;
        if (want == T_END)     nxt = HI;
        else if (n < 6'd10)    nxt = n[0] ? LO : GAP;
        else begin
`ifdef CHIME_STRIKE_EN
          if (n == 6'd10) begin
            nstrk_nxt = hr12;
            nxt       = STRIKE;
          end else if (s < {1'b0, nstrk, 1'b0}) begin
            nxt = s[0] ? GAP : STRIKE;
          end else begin
            nxt     = IDLE;
            idx_nxt = 6'd0;
          end
`else
          nxt     = IDLE;
          idx_nxt = 6'd0;
`endif
        end
      end
    end
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      state <= IDLE;
      idx   <= 6'd0;
      EN    <= 1'b0;
      Busy  <= 1'b0;
`ifdef CHIME_STRIKE_EN
      nstrk <= 4'd0;
`endif
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
      EN    <= is_tone(nxt);
      Busy  <= (nxt != IDLE);
`ifdef CHIME_STRIKE_EN
      nstrk <= nstrk_nxt;
`endif
    end
  end

  // Restart the divider on every tone entry so each pip begins at phase 0.
  assign clr = (nxt != state) || !is_tone(nxt);
`ifdef CHIME_STRIKE_EN
  assign sel_hi = (nxt == HI) || (nxt == STRIKE);
`else
  assign sel_hi = (nxt == HI);
`endif

  tone_div #(.DIV_LO(DIV_LO), .DIV_HI(DIV_HI)) u_div (
    .CP(CP), .nCR(nCR), .clr(clr), .sel_hi(sel_hi), .Beep(Beep)
  );

endmodule

// File: tb/tb_chime_gen.sv
// Scoreboard bench: each stimulated second pushes its expected Beep/EN/Busy
// profile; a monitor samples 16 cycles after every Tick and compares.
module tb_chime_gen;

  localparam int SECLEN = 16;

  logic       CP = 1'b0, nCR = 1'b0, Tick = 1'b0, ChimeOn = 1'b0;
  logic [3:0] MinH = 4'd0, MinL = 4'd0, SecH = 4'd0, SecL = 4'd0;
`ifdef CHIME_STRIKE_EN
  logic [3:0] HrH = 4'd0, HrL = 4'd0;
`endif
  logic       Beep, EN, Busy;

  typedef struct {
    logic [15:0] t;
    logic        en;
    logic        busy;
    int          p;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 CP = ~CP;

  chime_gen dut (
    .CP(CP), .nCR(nCR), .Tick(Tick),
    .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
`ifdef CHIME_STRIKE_EN
    .HrH(HrH), .HrL(HrL),
`endif
    .ChimeOn(ChimeOn), .Beep(Beep), .EN(EN), .Busy(Busy)
  );

  // Monitor: a second's profile is the 16 samples after its Tick edge.
  initial begin
    exp_t       e;
    bit         ok;
    int         bad_k;
    logic [2:0] got, want, bad_got, bad_want;
    forever begin
      @(posedge CP);
      if (Tick) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_tick: got a Tick with no expectation queued, required none");
        end else begin
          e = sb.pop_front();
          ok = 1'b1; bad_k = -1; bad_got = 3'b0; bad_want = 3'b0;
          for (int k = 0; k < SECLEN; k++) begin
            @(negedge CP);
            want = {(e.p == 0) ? 1'b0 : 1'((k / e.p) % 2), e.en, e.busy};
            got  = {Beep, EN, Busy};
            if (ok && got !== want) begin
              ok = 1'b0; bad_k = k; bad_got = got; bad_want = want;
            end
          end
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL sec_%h cycle %0d: beep/en/busy got %b required %b",
                     e.t, bad_k, bad_got, bad_want);
          end
        end
      end
    end
  end

  task automatic sec(input logic [15:0] t, input logic on, input logic on_mid,
                     input logic rst, input logic en, input logic busy, input int p);
    exp_t e;
    {MinH, MinL, SecH, SecL} = t;
    ChimeOn = on;
    nCR     = !rst;
    Tick    = 1'b1;
    e.t = t; e.en = en; e.busy = busy; e.p = p;
    sb.push_back(e);
    @(posedge CP); #1;
    Tick = 1'b0;
    nCR  = 1'b1;
    repeat (SECLEN/2 - 1) @(posedge CP);
    #1 ChimeOn = on_mid;
    repeat (SECLEN/2) @(posedge CP);
    #1;
  endtask

  // 59:50..59:59 with the chime enabled: ARM, LO/GAP x4, HI.
  task automatic run_pre();
    sec(16'h5950, 1, 1, 0, 0, 1, 0);
    for (int s = 1; s <= 8; s++)
      sec(16'(16'h5950 + s), 1, 1, 0, s[0], 1, s[0] ? 4 : 0);
    sec(16'h5959, 1, 1, 0, 1, 1, 2);
  endtask

  initial begin
    repeat (3) @(posedge CP);
    #1 nCR = 1'b1;

    // reset state, then an ordinary second
    sec(16'h0010, 1, 1, 0, 0, 0, 0);

    // full sequence
    sec(16'h5949, 1, 1, 0, 0, 0, 0);
`ifdef CHIME_STRIKE_EN
    HrH = 4'd1; HrL = 4'd3;
    run_pre();
    sec(16'h0000, 1, 1, 0, 1, 1, 2);
    sec(16'h0001, 1, 1, 0, 0, 1, 0);
    sec(16'h0002, 1, 1, 0, 0, 0, 0);
`else
    run_pre();
    sec(16'h0000, 1, 1, 0, 0, 0, 0);
    sec(16'h0001, 1, 1, 0, 0, 0, 0);
    sec(16'h0002, 1, 1, 0, 0, 0, 0);
`endif

    // chime disabled throughout
    for (int s = 0; s <= 9; s++)
      sec(16'(16'h5950 + s), 0, 0, 0, 0, 0, 0);
    sec(16'h0000, 0, 0, 0, 0, 0, 0);

    // time forced mid-sequence
    sec(16'h5950, 1, 1, 0, 0, 1, 0);
    sec(16'h5951, 1, 1, 0, 1, 1, 4);
    sec(16'h5952, 1, 1, 0, 0, 1, 0);
    sec(16'h5953, 1, 1, 0, 1, 1, 4);
    sec(16'h1200, 1, 1, 0, 0, 0, 0);
    sec(16'h1201, 1, 1, 0, 0, 0, 0);

    // reset at 59:55 discards the sequence
    sec(16'h5950, 1, 1, 0, 0, 1, 0);
    for (int s = 1; s <= 4; s++)
      sec(16'(16'h5950 + s), 1, 1, 0, s[0], 1, s[0] ? 4 : 0);
    sec(16'h5955, 1, 1, 1, 0, 0, 0);
    for (int s = 6; s <= 9; s++)
      sec(16'(16'h5950 + s), 1, 1, 0, 0, 0, 0);
    sec(16'h0000, 1, 1, 0, 0, 0, 0);

    // ChimeOn dropped halfway through the 59:55 tone
    sec(16'h5950, 1, 1, 0, 0, 1, 0);
    for (int s = 1; s <= 4; s++)
      sec(16'(16'h5950 + s), 1, 1, 0, s[0], 1, s[0] ? 4 : 0);
    sec(16'h5955, 1, 0, 0, 1, 1, 4);
    sec(16'h5956, 0, 0, 0, 0, 0, 0);
    sec(16'h5957, 1, 1, 0, 0, 0, 0);

`ifdef CHIME_STRIKE_EN
    // 15:00 -> three strikes
    HrH = 4'd1; HrL = 4'd5;
    run_pre();
    for (int s = 0; s <= 5; s++)
      sec(16'(s), 1, 1, 0, !s[0], 1, s[0] ? 0 : 2);
    sec(16'h0006, 1, 1, 0, 0, 0, 0);

    // 00:00 -> twelve strikes, last silent second is 00:23
    HrH = 4'd0; HrL = 4'd0;
    run_pre();
    for (int s = 0; s <= 23; s++)
      sec({8'h00, 4'(s / 10), 4'(s % 10)}, 1, 1, 0, !s[0], 1, s[0] ? 0 : 2);
    sec(16'h0024, 1, 1, 0, 0, 0, 0);
    sec(16'h0025, 1, 1, 0, 0, 0, 0);
`endif

    repeat (2 * SECLEN) @(posedge CP);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d unchecked seconds, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chime_gen.md
CHIME_GEN -- requirements
Module: chime_gen

Interface
REQ-001 SHALL have parameter DIV_LO, default 4, meaning the half-period of the low tone in CP cycles.
REQ-002 SHALL have parameter DIV_HI, default 2, meaning the half-period of the high tone in CP cycles; the constraint is 1 <= DIV_HI < DIV_LO <= 255.
REQ-003 SHALL have port CP, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port nCR, input, 1 bit: reset that is synchronous and active-low.
REQ-005 SHALL have port Tick, input, 1 bit: a one-CP-cycle pulse once per second, coincident with the seconds-counter update.
REQ-006 SHALL have ports MinH, MinL, SecH, SecL, inputs, 4 bits each: the current BCD time, valid in the cycle Tick is high.
REQ-007 SHALL have port ChimeOn, input, 1 bit: the user chime enable.
REQ-008 SHALL have port Beep, output, 1 bit: the square-wave tone to the speaker.
REQ-009 SHALL have port EN, output, 1 bit: the enable to the hourly LED toggler, high while any tone sounds.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever the FSM is outside IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, ARM, LO, GAP, HI and STRIKE; STRIKE exists only with the macro.
REQ-012 SHALL go IDLE->ARM on a Tick with time 59:50 and ChimeOn=1; no other condition leaves IDLE.
REQ-013 SHALL track the expected second internally (0..9 after 59:50, with 9 = 59:59) and advance it once per Tick.
REQ-014 SHALL be in LO during expected seconds 51, 53, 55 and 57 and in GAP during seconds 52, 54, 56 and 58.
REQ-015 SHALL be in HI during second 59 and SHALL return to IDLE on the Tick showing 00:00, unless strike mode applies.
REQ-016 SHALL have a tone state that lasts exactly from one Tick to the next, so state changes occur in the Tick cycle.
REQ-017 SHALL abort to IDLE in the same cycle, with Beep=0 and EN=0, if on any Tick in a non-IDLE state the input time differs from the expected time (time set or adjust).
REQ-018 SHALL return to IDLE at the next Tick if ChimeOn falls mid-sequence; a tone already sounding completes its second.
REQ-019 SHALL produce the tone with an 8-bit divider counter that toggles Beep when it reaches DIV-1 and then wraps to 0; the divider is DIV_LO in LO and DIV_HI in HI and STRIKE.
REQ-020 SHALL clear the divider counter and Beep to 0 on every entry to a tone state, so each tone starts at phase 0.
REQ-021 SHALL hold Beep=0 in IDLE, ARM and GAP.
REQ-022 SHALL assert EN exactly when the FSM is in LO, HI or STRIKE.
REQ-023 SHALL register all outputs, giving a latency of 1 CP cycle from the Tick edge to the state and output change.

Reset
REQ-024 SHALL, when nCR=0 at an edge, set state to IDLE, Beep=0, EN=0, Busy=0 and all counters to 0, with priority over Tick.
REQ-025 SHALL discard an interrupted sequence on reset mid-sequence; no tone resumes until the next 59:50.

Configuration
REQ-026 SHALL use the macro CHIME_STRIKE_EN to compile in hour striking; when it is defined, the block SHALL add inputs HrH and HrL (BCD, 24-hour).
REQ-027 SHALL, with CHIME_STRIKE_EN, capture N = hour mod 12 on the 00:00 Tick after HI, where a value of 0 gives N=12.
REQ-028 SHALL, with CHIME_STRIKE_EN, strike with the high tone during even seconds 00..2(N-1) and silence during odd seconds, then go to IDLE on the Tick after the last silent second.
REQ-029 SHALL apply the abort rule during STRIKE, checked against the expected 00:SS.
REQ-030 SHALL, without CHIME_STRIKE_EN, omit HrH/HrL and the STRIKE state, and go HI->IDLE at 00:00.

Structure
REQ-031 SHALL place the state encoding, the constants for chime start and end times (59:50, 59:59) and the default dividers in shared package clock_pkg.
REQ-032 SHALL put the tone divider in sub-module tone_div (inputs CP, nCR, clr, sel_hi; output Beep).

Verification
REQ-033 SHALL cover: ChimeOn=1, time stepped 59:49..00:01 with Tick -> Beep toggles every 4 CP cycles during 51/53/55/57, every 2 CP cycles during 59, and is 0 elsewhere; EN mirrors the tone seconds.
REQ-034 SHALL cover: ChimeOn=0 across 59:50..00:00 -> Beep=0, EN=0, Busy=0 throughout.
REQ-035 SHALL cover: time forced from 59:53 to 12:00 on a Tick -> IDLE in the same cycle, with Beep=0 and Busy=0.
REQ-036 SHALL cover: nCR=0 for one edge at 59:55 -> all outputs 0, and no tone at 59:57 or 59:59.
REQ-037 SHALL cover: CHIME_STRIKE_EN with hour 15:00 -> 3 high-tone seconds at 00, 02 and 04; with 00:00 -> 12 strikes ending after second 23.
REQ-038 SHALL cover: ChimeOn dropped mid-tone at 59:55 -> that tone completes, and IDLE is reached at the 59:56 Tick.
